// File: rtl/icache_pkg.sv
// Shared types and AXI encodings for the icache line-refill engine.
package icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Byte offset of the set index inside an address: log2 of the line size in bytes.
    function automatic int line_off(input int beats, input int data_width);
        return $clog2(beats * data_width / 8);
    endfunction

endpackage

// File: rtl/icache_axi_refill.sv
// Icache line-refill engine: one AXI4 read burst per miss, beats written to per-beat banks.
// ICACHE_REFILL_WRAP_EN selects critical-word-first WRAP bursts; default is line-aligned INCR.
module icache_axi_refill
    import icache_pkg::*;
#(
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 64,
    parameter int LineBeats    = 4,
    parameter int MemAddrWidth = 10,
    parameter int AxiIdWidth   = 4,
    parameter int AxiId        = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [AddrWidth-1:0]      i_req_addr,
    output logic                      o_req_done,
    output logic                      o_req_error,
    output logic                      o_ar_valid,
    input  logic                      i_ar_ready,
    output logic [AddrWidth-1:0]      o_ar_addr,
    output logic [7:0]                o_ar_len,
    output logic [2:0]                o_ar_size,
    output logic [1:0]                o_ar_burst,
    output logic [AxiIdWidth-1:0]     o_ar_id,
    input  logic                      i_r_valid,
    output logic                      o_r_ready,
    input  logic [DataWidth-1:0]      i_r_data,
    input  logic [1:0]                i_r_resp,
    input  logic                      i_r_last,
    input  logic [AxiIdWidth-1:0]     i_r_id,
    output logic [LineBeats-1:0]      o_mem_en,
    output logic [DataWidth/8-1:0]    o_mem_we,
    output logic [MemAddrWidth-1:0]   o_mem_addr,
    output logic [DataWidth-1:0]      o_mem_din
);

    localparam int Off     = line_off(LineBeats, DataWidth);
    localparam int BeatOff = $clog2(DataWidth / 8);
    localparam int IdxW    = $clog2(LineBeats);
    localparam logic [IdxW-1:0] LastCnt = IdxW'(LineBeats - 1);

    state_e                   r_state;
    logic [AddrWidth-1:0]     r_addr;
    logic [IdxW-1:0]          r_idx;
    logic [IdxW-1:0]          r_cnt;
    logic                     r_err;
    logic                     r_req_done;
    logic [LineBeats-1:0]     r_mem_en;
    logic [DataWidth/8-1:0]   r_mem_we;
    logic [MemAddrWidth-1:0]  r_mem_addr;
    logic [DataWidth-1:0]     r_mem_din;

    logic                     w_bad_beat;
    logic                     w_last_cnt;
    logic [IdxW-1:0]          w_idx_start;
    logic [AddrWidth-1:0]     w_ar_addr;

    assign w_bad_beat = (i_r_resp != RESP_OKAY) || (i_r_id != AxiIdWidth'(AxiId));
    assign w_last_cnt = (r_cnt == LastCnt);

`ifdef ICACHE_REFILL_WRAP_EN
    assign w_idx_start = i_req_addr[Off-1 -: IdxW];
    assign w_ar_addr   = r_addr & {{(AddrWidth-BeatOff){1'b1}}, {BeatOff{1'b0}}};
    assign o_ar_burst  = BURST_WRAP;
`else
    assign w_idx_start = '0;
    assign w_ar_addr   = r_addr & {{(AddrWidth-Off){1'b1}}, {Off{1'b0}}};
    assign o_ar_burst  = BURST_INCR;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_req_done <= 1'b0;
            r_mem_en   <= '0;
            r_mem_we   <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_en   <= '0;
            r_mem_we   <= '0;
            r_req_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_addr  <= i_req_addr;
                        r_idx   <= w_idx_start;
                        r_cnt   <= '0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (i_ar_ready) r_state <= ST_DATA;
                end
                ST_DATA: begin
                    if (i_r_valid) begin
                        r_mem_addr <= r_addr[Off +: MemAddrWidth];
                        r_mem_din  <= i_r_data;
                        if (!r_err && !w_bad_beat) begin
                            r_mem_en <= LineBeats'(1) << r_idx;
                            r_mem_we <= '1;
                        end
                        // A misplaced or missing r_last flags the line but keeps this beat's data.
                        if (w_bad_beat || (i_r_last != w_last_cnt)) r_err <= 1'b1;
                        r_idx <= r_idx + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_cnt || i_r_last) r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // First DONE cycle covers the final bank write; done pulses in the second.
                    if (!r_req_done) begin
                        r_req_done <= 1'b1;
                    end else begin
                        r_err   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_ar_valid  = (r_state == ST_ADDR);
    assign o_ar_addr   = w_ar_addr;
    assign o_ar_len    = 8'(LineBeats - 1);
    assign o_ar_size   = 3'(BeatOff);
    assign o_ar_id     = AxiIdWidth'(AxiId);
    assign o_r_ready   = (r_state == ST_DATA);
    assign o_req_done  = r_req_done;
    assign o_req_error = r_req_done & r_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_din   = r_mem_din;

endmodule

// File: tb/tb_icache_axi_refill.sv
// Self-checking bench for icache_axi_refill; follows ICACHE_REFILL_WRAP_EN like the design.
module tb_icache_axi_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        ar_ready = 1'b0;
    logic        r_valid = 1'b0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;
    logic        r_last = 1'b0;
    logic [3:0]  r_id = '0;

    logic        o_req_ready, o_req_done, o_req_error, o_ar_valid, o_r_ready;
    logic [31:0] o_ar_addr;
    logic [7:0]  o_ar_len;
    logic [2:0]  o_ar_size;
    logic [1:0]  o_ar_burst;
    logic [3:0]  o_ar_id;
    logic [3:0]  o_mem_en;
    logic [7:0]  o_mem_we;
    logic [9:0]  o_mem_addr;
    logic [63:0] o_mem_din;

    icache_axi_refill dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_addr(req_addr),
        .o_req_done(o_req_done), .o_req_error(o_req_error),
        .o_ar_valid(o_ar_valid), .i_ar_ready(ar_ready), .o_ar_addr(o_ar_addr),
        .o_ar_len(o_ar_len), .o_ar_size(o_ar_size), .o_ar_burst(o_ar_burst), .o_ar_id(o_ar_id),
        .i_r_valid(r_valid), .o_r_ready(o_r_ready), .i_r_data(r_data), .i_r_resp(r_resp),
        .i_r_last(r_last), .i_r_id(r_id),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din)
    );

    always #5 clk = ~clk;

`ifdef ICACHE_REFILL_WRAP_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model expectations for the current cycle
    logic        exp_req_ready, exp_ar_valid, exp_r_ready, exp_req_done, exp_req_error;
    logic [31:0] exp_ar_addr;
    logic [3:0]  exp_mem_en;
    logic [9:0]  exp_mem_addr;
    logic [63:0] exp_mem_din;

    // Observations used to pin the model with literal values
    int          done_at = 0;
    logic        cap_err = 1'b0;
    logic [31:0] cap_ar = '0;
    logic [9:0]  cap_mem_addr = '0;
    logic [31:0] cap_order = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_ready", o_req_ready, exp_req_ready);
        chk("ar_valid", o_ar_valid, exp_ar_valid);
        if (exp_ar_valid) chk("ar_addr", o_ar_addr, exp_ar_addr);
        chk("ar_len", o_ar_len, 8'd3);
        chk("ar_size", o_ar_size, 3'd3);
        chk("ar_burst", o_ar_burst, EXP_BURST);
        chk("ar_id", o_ar_id, 4'd0);
        chk("r_ready", o_r_ready, exp_r_ready);
        chk("mem_en", o_mem_en, exp_mem_en);
        chk("mem_we", o_mem_we, (exp_mem_en != 4'd0) ? 8'hFF : 8'h00);
        if (exp_mem_en != 4'd0) begin
            chk("mem_addr", o_mem_addr, exp_mem_addr);
            chk("mem_din", o_mem_din, exp_mem_din);
        end
        chk("req_done", o_req_done, exp_req_done);
        chk("req_error", o_req_error, exp_req_error);
        if (o_ar_valid) cap_ar = o_ar_addr;
        if (o_mem_en != 4'd0) begin
            cap_order    = (cap_order << 4) | 32'(o_mem_en);
            cap_mem_addr = o_mem_addr;
        end
        if (o_req_done) begin
            done_at = cyc;
            cap_err = o_req_error;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_req_ready = 1'b1; exp_ar_valid = 1'b0; exp_r_ready = 1'b0;
        exp_mem_en = '0; exp_req_done = 1'b0; exp_req_error = 1'b0;
    endtask

    task automatic reset_exp();
        idle_exp();
        exp_req_ready = 1'b0;
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int k);
        return {a, 32'hBEA7_0000 + 32'(k)};
    endfunction

    // One refill, cycle by cycle. Negative bad_beat/early_last/rst_beat disable that feature.
    task automatic run_txn(input logic [31:0] addr, input int ar_delay, input bit r_gap,
                           input bit noise, input int bad_beat, input bit bad_is_id,
                           input int early_last, input bit no_last, input int rst_beat,
                           output int rel_done);
        int          start, nbeats, k, t0;
        logic [31:0] ar_exp;
        logic [3:0]  pend_en;
        logic [63:0] pend_din;
        bit          err, gap_ph;
`ifdef ICACHE_REFILL_WRAP_EN
        start  = int'(addr[4:3]);
        ar_exp = {addr[31:3], 3'b000};
`else
        start  = 0;
        ar_exp = {addr[31:5], 5'b00000};
`endif
        nbeats   = (early_last >= 0) ? early_last + 1 : 4;
        err      = (early_last >= 0) || no_last || (bad_beat >= 0 && bad_beat < nbeats);
        rel_done = -1;
        cap_order = '0;
        pend_en  = '0;
        pend_din = '0;

        idle_exp();
        req_valid = 1'b1; req_addr = addr; t0 = cyc;
        tick();
        req_valid = noise;
        exp_req_ready = 1'b0;
        for (int d = 0; d <= ar_delay; d++) begin
            exp_ar_valid = 1'b1; exp_ar_addr = ar_exp;
            ar_ready = (d == ar_delay);
            r_valid = noise; r_data = '1; r_last = noise;
            tick();
        end
        ar_ready = 1'b0; exp_ar_valid = 1'b0; r_last = 1'b0;

        k = 0; gap_ph = r_gap;
        while (k < nbeats) begin
            exp_r_ready = 1'b1;
            exp_mem_en = pend_en; exp_mem_addr = addr[14:5]; exp_mem_din = pend_din;
            pend_en = '0;
            if (k == rst_beat) begin
                rst = 1'b1; r_valid = 1'b0; req_valid = 1'b0;
                reset_exp();
                tick();
                tick();
                rst = 1'b0;
                idle_exp();
                tick();
                return;
            end
            if (gap_ph) begin
                r_valid = 1'b0; r_data = '1;
            end else begin
                r_valid = 1'b1;
                r_data  = beat_data(addr, k);
                r_resp  = (k == bad_beat && !bad_is_id) ? 2'b10 : 2'b00;
                r_id    = (k == bad_beat && bad_is_id) ? 4'h5 : 4'h0;
                r_last  = (early_last >= 0) ? (k == early_last) : (!no_last && k == 3);
                if (bad_beat < 0 || k < bad_beat) pend_en = 4'b0001 << ((start + k) % 4);
                pend_din = beat_data(addr, k);
                k++;
            end
            if (r_gap) gap_ph = !gap_ph;
            tick();
        end
        r_valid = noise; r_last = 1'b0; r_resp = '0; r_id = '0;
        exp_r_ready = 1'b0; exp_mem_en = pend_en; exp_mem_din = pend_din;
        tick();
        exp_mem_en = '0; exp_req_done = 1'b1; exp_req_error = err; req_valid = 1'b0;
        tick();
        r_valid = 1'b0;
        idle_exp();
        tick();
        rel_done = done_at - t0;
    endtask

    int rel;

    initial begin
        reset_exp();
        tick();
        tick();
        rst = 1'b0;
        idle_exp();
        tick();

        // Zero-wait line refill
        run_txn(32'h0000_1234, 0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, -1, rel);
        chk("t1_done_cycle", 64'(rel), 64'd7);
        chk("t1_error", cap_err, 1'b0);
        chk("t1_mem_addr", cap_mem_addr, 10'h091);
`ifdef ICACHE_REFILL_WRAP_EN
        chk("t1_ar_addr", cap_ar, 32'h0000_1230);
        chk("t1_bank_order", cap_order, 32'h4812);
`else
        chk("t1_ar_addr", cap_ar, 32'h0000_1220);
        chk("t1_bank_order", cap_order, 32'h1248);
`endif

        // Slow AR, gapped R, stray req_valid/r_valid outside their states
        run_txn(32'h0000_6000, 5, 1'b1, 1'b1, -1, 1'b0, -1, 1'b0, -1, rel);
        chk("t2_done_cycle", 64'(rel), 64'd16);
        chk("t2_bank_order", cap_order, 32'h1248);
        chk("t2_error", cap_err, 1'b0);

        // SLVERR on beat 2
        run_txn(32'h0000_2000, 0, 1'b0, 1'b0, 2, 1'b0, -1, 1'b0, -1, rel);
        chk("t3_bank_order", cap_order, 32'h0012);
        chk("t3_error", cap_err, 1'b1);

        // Early r_last on beat 1
        run_txn(32'h0000_3000, 0, 1'b0, 1'b0, -1, 1'b0, 1, 1'b0, -1, rel);
        chk("t4_done_cycle", 64'(rel), 64'd5);
        chk("t4_error", cap_err, 1'b1);

        // Wrong RID on the first beat: nothing written
        run_txn(32'h0000_4000, 0, 1'b0, 1'b0, 0, 1'b1, -1, 1'b0, -1, rel);
        chk("t5_bank_order", cap_order, 32'h0000);
        chk("t5_error", cap_err, 1'b1);

        // Missing r_last on the final beat
        run_txn(32'h0000_5008, 0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b1, -1, rel);
        chk("t6_done_cycle", 64'(rel), 64'd7);
        chk("t6_error", cap_err, 1'b1);

        // Reset during beat 2, then a clean refill
        run_txn(32'h0000_7000, 0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, 2, rel);
        run_txn(32'h0000_7040, 0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, -1, rel);
        chk("t7_done_cycle", 64'(rel), 64'd7);
        chk("t7_error", cap_err, 1'b0);

        // Critical-word address
        run_txn(32'h0000_1230, 0, 1'b0, 1'b0, -1, 1'b0, -1, 1'b0, -1, rel);
`ifdef ICACHE_REFILL_WRAP_EN
        chk("t8_ar_addr", cap_ar, 32'h0000_1230);
        chk("t8_bank_order", cap_order, 32'h4812);
`else
        chk("t8_ar_addr", cap_ar, 32'h0000_1220);
        chk("t8_bank_order", cap_order, 32'h1248);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

Instruction-cache line-refill engine between the icache controller and the AXI4 read fabric. Accepts one line-miss request from the controller via the `axi_req_if` handshake and issues a single AXI4 read burst for the line. Writes each returned beat into the matching data-RAM bank through a `mem_if`-style write port, then reports completion and error status to the controller.

## Interface
- `AddrWidth`, 32, physical address width
- `DataWidth`, 64, AXI data bus and bank word width
- `LineBeats`, 4, beats per cache line; equals number of data banks
- `MemAddrWidth`, 10, bank (set index) address width
- `AxiIdWidth`, 4, ARID/RID width
- `AxiId`, 0, constant ID used for refill reads

Reset is asynchronous and active-high; one clock.

- `clk` in 1 — single clock
- `rst` in 1 — async active-high reset
- `req_valid` in 1 — controller requests line refill
- `req_ready` out 1 — engine idle, request accepted
- `req_addr` in AddrWidth — miss address
- `req_done` out 1 — one-cycle pulse when the line is written
- `req_error` out 1 — qualifies `req_done`; bad response seen
- `ar_valid`/`ar_ready` out/in 1 — AXI AR handshake
- `ar_addr` out AddrWidth
- `ar_len` out 8 — constant LineBeats-1
- `ar_size` out 3 — log2(DataWidth/8)
- `ar_burst` out 2
- `ar_id` out AxiIdWidth
- `r_valid`/`r_ready` in/out 1 — AXI R handshake
- `r_data` in DataWidth
- `r_resp` in 2
- `r_last` in 1
- `r_id` in AxiIdWidth
- `mem_en` out LineBeats — one-hot bank select
- `mem_we` out DataWidth/8 — byte write enables
- `mem_addr` out MemAddrWidth — set index
- `mem_din` out DataWidth — write data

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- **IDLE:** `req_ready`=1. When `req_valid`, register `req_addr` and move to ADDR.
- **ADDR:** `ar_valid`=1, with address and fields stable until `ar_ready`. On the handshake, move to DATA.
- **DATA:** `r_ready`=1. Each accepted beat registers a write with:
  - `mem_en` one-hot at the current beat index
  - `mem_we` all ones
  - `mem_addr` = `req_addr[Off +: MemAddrWidth]`, where Off = log2(LineBeats*DataWidth/8)
  - `mem_din` = `r_data`
- Beat index is a log2(LineBeats)-bit counter; it increments per accepted beat and wraps modulo LineBeats.
- Beat count is a separate counter of 0..LineBeats-1. On the last counted beat, move to DONE.
- **Error conditions** set a sticky error flag and suppress `mem_en`/`mem_we` for that beat and all later beats:
  - `r_resp` ≠ OKAY (0b00)
  - `r_id` ≠ `AxiId`
- **rlast checks** (both set the error flag):
  - `r_last` on a beat before the last → terminate and go to DONE.
  - `r_last` absent on the last counted beat → go to DONE anyway.
- **DONE:** `req_done`=1 for exactly one cycle; `req_error` = error flag. Clear the flag and return to IDLE.

## Timing
- Reset values: all outputs 0; `ar_len`/`ar_size`/`ar_burst`/`ar_id` constant. FSM in IDLE, counters 0, error flag 0.
- Request accept to `ar_valid`: 1 cycle.
- R beat accepted at cycle n → bank write asserted at cycle n+1, for one cycle.
- `req_done` asserts in the cycle after the last bank write; `req_ready` is 1 again the cycle after that.
- With zero-wait AR and back-to-back R: accept to `req_done` = LineBeats+3 cycles.
- `req_ready` is 0 outside IDLE; `req_valid` is ignored there.
- `r_valid` in IDLE/ADDR/DONE is not accepted (`r_ready`=0).
- Reset mid-burst: immediate return to reset values. The fabric is reset in the same domain, so no outstanding-burst drain is performed.

## Configuration
- `ICACHE_REFILL_WRAP_EN` defined: critical-word-first refill.
  - `ar_burst` = WRAP (0b10).
  - `ar_addr` = `req_addr` aligned to the beat.
  - Beat index starts at `req_addr[Off-1 -: log2(LineBeats)]` and wraps.
- Undefined:
  - `ar_burst` = INCR (0b01).
  - `ar_addr` = `req_addr` aligned to the line.
  - Beat index starts at 0.
- All other behaviour is identical in both builds.

## Structure
- Shared `icache_pkg` holds:
  - FSM state enum
  - AXI burst and response encodings (INCR, WRAP, OKAY)
  - line offset constant derivation
- No sub-modules; a single flat FSM plus datapath.

## Test plan
- INCR, `req_addr`=0x0000_1234, zero-wait AR/R, OKAY → `ar_addr`=0x1220, `ar_len`=3; banks 0..3 written at `mem_addr`=0x091 with beats D0..D3; `req_done` at cycle 7; `req_error`=0.
- `r_valid` toggling every other cycle plus `ar_ready` delayed 5 cycles → AR fields stable throughout; 4 writes total; no write in non-beat cycles.
- SLVERR on beat 2 → banks 0,1 written; beats 2,3 not written; `req_done` with `req_error`=1.
- `r_last` on beat 1 → FSM exits after 2 beats; `req_error`=1; IDLE 1 cycle later.
- `rst` asserted during beat 2 → all outputs 0 immediately; a new request afterwards completes cleanly.
- WRAP build, `req_addr`=0x1230 → `ar_addr`=0x1230, `ar_burst`=0b10; bank order 2,3,0,1.
